// File: rtl/bcd_counter_n.sv
// bcd_counter_n: DIGITS-decade cascaded BCD up/down counter with parallel load,
// terminal count, cascade carry, sticky overflow and illegal-load flag.
//
// Build option: define BCD_COUNTER_DOWN_EN to honour up_down. When it is not
// defined the up_down port is present but ignored and the counter only counts up.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset
//   enable      in   count step request
//   up_down     in   1 = up, 0 = down (down only with BCD_COUNTER_DOWN_EN)
//   load        in   synchronous parallel load strobe (wins over enable)
//   load_value  in   4*DIGITS BCD load value, digit 0 in [3:0]
//   clear_ovf   in   synchronous clear of overflow (set wins on a tie)
//   digits      out  4*DIGITS current count, digit 0 in [3:0]
//   tc          out  terminal count for the current direction (combinational)
//   carry_out   out  tc & enable & ~load, cascade to a following counter
//   overflow    out  sticky wrap flag
//   load_error  out  one-cycle pulse after a load containing a digit above 9
module bcd_counter_n #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  clear_ovf,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  tc,
  output logic                  carry_out,
  output logic                  overflow,
  output logic                  load_error
);

  logic [4*DIGITS-1:0] r_digits;
  logic                r_overflow;
  logic                r_load_error;

  logic                w_up;
  logic                w_step;
  logic                w_all9;
  logic                w_all0;
  logic                w_tc;
  logic                w_load_bad;
  logic [4*DIGITS-1:0] w_load_clean;
  logic [4*DIGITS-1:0] w_next;
  logic                w_lower9;
  logic                w_lower0;

`ifdef BCD_COUNTER_DOWN_EN
  assign w_up = up_down;
`else
  assign w_up = 1'b1;
`endif

  // Load takes priority, so a step only happens without a load.
  assign w_step = enable & ~load;

  // Ripple through the decades: a decade moves only when every lower decade
  // is at its wrap value for the current direction.
  always_comb begin
    w_lower9     = 1'b1;
    w_lower0     = 1'b1;
    w_load_bad   = 1'b0;
    w_load_clean = '0;
    w_next       = r_digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_value[4*k +: 4] > 4'd9) begin
        w_load_bad = 1'b1;
      end else begin
        w_load_clean[4*k +: 4] = load_value[4*k +: 4];
      end

      if (w_up) begin
        if (w_lower9) begin
          w_next[4*k +: 4] = (r_digits[4*k +: 4] == 4'd9) ? 4'd0 : r_digits[4*k +: 4] + 4'd1;
        end
      end else begin
        if (w_lower0) begin
          w_next[4*k +: 4] = (r_digits[4*k +: 4] == 4'd0) ? 4'd9 : r_digits[4*k +: 4] - 4'd1;
        end
      end

      w_lower9 = w_lower9 & (r_digits[4*k +: 4] == 4'd9);
      w_lower0 = w_lower0 & (r_digits[4*k +: 4] == 4'd0);
    end
    w_all9 = w_lower9;
    w_all0 = w_lower0;
  end

  assign w_tc = w_up ? w_all9 : w_all0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_digits     <= '0;
      r_overflow   <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_load_error <= load & w_load_bad;
      if (load) begin
        r_digits <= w_load_clean;
      end else if (enable) begin
        r_digits <= w_next;
      end
      // Set dominates clear when both happen on the same edge.
      if (w_step && w_tc) begin
        r_overflow <= 1'b1;
      end else if (clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign digits     = r_digits;
  assign tc         = w_tc;
  assign carry_out  = w_tc & w_step;
  assign overflow   = r_overflow;
  assign load_error = r_load_error;

endmodule

// File: tb/tb_bcd_counter_n.sv
module tb_bcd_counter_n;

  logic        clock = 1'b0;
  logic        reset;

  logic        en4, ud4, ld4, clr4;
  logic [15:0] lv4;
  logic [15:0] dig4;
  logic        tc4, co4, ovf4, lerr4;

  logic        en2, ud2, ld2, clr2;
  logic [7:0]  lv2;
  logic [7:0]  dig2;
  logic        tc2, co2, ovf2, lerr2;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  bcd_counter_n #(.DIGITS(4)) u_dut4 (
    .clock      (clock),
    .reset      (reset),
    .enable     (en4),
    .up_down    (ud4),
    .load       (ld4),
    .load_value (lv4),
    .clear_ovf  (clr4),
    .digits     (dig4),
    .tc         (tc4),
    .carry_out  (co4),
    .overflow   (ovf4),
    .load_error (lerr4)
  );

  bcd_counter_n #(.DIGITS(2)) u_dut2 (
    .clock      (clock),
    .reset      (reset),
    .enable     (en2),
    .up_down    (ud2),
    .load       (ld2),
    .load_value (lv2),
    .clear_ovf  (clr2),
    .digits     (dig2),
    .tc         (tc2),
    .carry_out  (co2),
    .overflow   (ovf2),
    .load_error (lerr2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int n);
    return 8'(((n / 10) << 4) | (n % 10));
  endfunction

  initial begin
    int n;
    logic exp_ovf;

    reset = 1'b1;
    en4 = 0; ud4 = 1; ld4 = 0; clr4 = 0; lv4 = '0;
    en2 = 0; ud2 = 1; ld2 = 0; clr2 = 0; lv2 = '0;
    #2;
    check("rst_digits", 32'(dig4), 32'h0);
    check("rst_ovf", 32'(ovf4), 32'h0);
    check("rst_lerr", 32'(lerr4), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Two-decade counter through a full wrap.
    en2 = 1'b1;
    n = 0;
    exp_ovf = 1'b0;
    check("d2_start", 32'(dig2), 32'h00);
    for (int i = 0; i < 100; i++) begin
      check("d2_tc", 32'(tc2), 32'(n == 99));
      tick();
      if (n == 99) exp_ovf = 1'b1;
      n = (n + 1) % 100;
      check("d2_digits", 32'(dig2), 32'(bcd2(n)));
      check("d2_ovf", 32'(ovf2), 32'(exp_ovf));
    end
    en2 = 1'b0;

    // Load, then ripple carry up across decades.
    ld4 = 1'b1; lv4 = 16'h0999;
    tick();
    check("ld_0999", 32'(dig4), 32'h0999);
    check("ld_0999_lerr", 32'(lerr4), 32'h0);
    ld4 = 1'b0; en4 = 1'b1; ud4 = 1'b1;
    tick();
    check("up_1000", 32'(dig4), 32'h1000);
    check("up_1000_ovf", 32'(ovf4), 32'h0);
`ifdef BCD_COUNTER_DOWN_EN
    ud4 = 1'b0;
    tick();
    check("dn_0999", 32'(dig4), 32'h0999);
    check("dn_0999_ovf", 32'(ovf4), 32'h0);
    ud4 = 1'b1;
`endif
    en4 = 1'b0;

    // Illegal digit in a load is replaced by 0 and flagged for one cycle.
    ld4 = 1'b1; lv4 = 16'h12A4;
    tick();
    check("ld_12a4", 32'(dig4), 32'h1204);
    check("ld_12a4_lerr", 32'(lerr4), 32'h1);

    // Load coinciding with enable: load wins, no overflow.
    lv4 = 16'h9999; en4 = 1'b1;
    tick();
    check("ld_en_digits", 32'(dig4), 32'h9999);
    check("ld_en_ovf", 32'(ovf4), 32'h0);
    check("lerr_pulse_end", 32'(lerr4), 32'h0);
    ld4 = 1'b0;
    #1;
    check("tc_9999", 32'(tc4), 32'h1);
    check("co_9999", 32'(co4), 32'h1);
    ld4 = 1'b1;
    #1;
    check("co_blocked_by_load", 32'(co4), 32'h0);
    ld4 = 1'b0;
    tick();
    check("wrap_0000", 32'(dig4), 32'h0000);
    check("wrap_ovf", 32'(ovf4), 32'h1);
    en4 = 1'b0; clr4 = 1'b1;
    tick();
    check("clr_ovf", 32'(ovf4), 32'h0);
    clr4 = 1'b0;

    ud4 = 1'b0;
    #1;
`ifdef BCD_COUNTER_DOWN_EN
    check("tc_dn_0000", 32'(tc4), 32'h1);
    en4 = 1'b1;
    tick();
    check("dn_wrap_9999", 32'(dig4), 32'h9999);
    check("dn_wrap_ovf", 32'(ovf4), 32'h1);
    // Switch direction so the next step wraps, with clear_ovf on the same edge.
    ud4 = 1'b1; clr4 = 1'b1;
    #1;
    check("tc_follows_dir", 32'(tc4), 32'h1);
    tick();
    check("set_clr_digits", 32'(dig4), 32'h0000);
    check("set_clr_ovf", 32'(ovf4), 32'h1);
    clr4 = 1'b0; en4 = 1'b0;
`else
    check("tc_uponly_0000", 32'(tc4), 32'h0);
    en4 = 1'b1;
    tick();
    check("uponly_0001", 32'(dig4), 32'h0001);
    check("uponly_ovf", 32'(ovf4), 32'h0);
    en4 = 1'b0; ld4 = 1'b1; lv4 = 16'h9999;
    tick();
    ld4 = 1'b0; en4 = 1'b1; clr4 = 1'b1;
    tick();
    check("set_clr_digits", 32'(dig4), 32'h0000);
    check("set_clr_ovf", 32'(ovf4), 32'h1);
    clr4 = 1'b0; en4 = 1'b0;
`endif

    // Asynchronous reset mid-count.
    ud4 = 1'b1; en4 = 1'b1;
    tick();
    check("pre_rst_digits", 32'(dig4), 32'h0001);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_digits", 32'(dig4), 32'h0);
    check("async_rst_ovf", 32'(ovf4), 32'h0);
    #2;
    reset = 1'b0;
    tick();
    check("post_rst_0001", 32'(dig4), 32'h0001);
    en4 = 1'b0;
    tick();
    check("hold_0001", 32'(dig4), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
